// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the gray_conv_arbiter block: FSM state encoding,
// code-conversion functions and direction constants.
package gray_conv_pkg;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } conv_state_e;

    localparam logic DIR_B2G = 1'b0;
    localparam logic DIR_G2B = 1'b1;

    localparam int unsigned MAX_W = 32;

    // Binary -> Gray over the low `width` bits; bits at and above `width` are zero.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] w,
                                                  input int unsigned width);
        logic [MAX_W-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < int'(width)) begin
                res[i] = (i + 1 < int'(width)) ? (w[i] ^ w[i+1]) : w[i];
            end
        end
        return res;
    endfunction

    // Gray -> binary: prefix XOR running from the MSB of the `width`-bit field down.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] w,
                                                  input int unsigned width);
        logic [MAX_W-1:0] res;
        logic             acc;
        res = '0;
        acc = 1'b0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (i < int'(width)) begin
                acc    = acc ^ w[i];
                res[i] = acc;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/gray_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping to the lowest valid index when nothing at or above ptr is valid.
module gray_rr_picker #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  winner,
    output logic            any_valid
);

    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] masked;
    logic [NREQ-1:0] cand;
    logic            found;

    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            mask[i] = (i >= int'(ptr));
        end
        masked    = req_valid & mask;
        // Nothing valid at or above ptr: wrap around to the full vector.
        cand      = (|masked) ? masked : req_valid;
        any_valid = |req_valid;

        grant  = '0;
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (cand[i] && !found) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                winner   = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared binary<->Gray conversion stage with valid/ready on every side.
// Optional macro GRAY_CONV_DECODE_EN adds per-requester req_dir (1 = Gray->binary).
module gray_conv_arbiter
    import gray_conv_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_bin,
`ifdef GRAY_CONV_DECODE_EN
    input  logic [NREQ-1:0]       req_dir,
`endif
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_gray,
    output logic [IDW-1:0]        out_id,
    input  logic                  out_ready
);

    conv_state_e      state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_gray_q;
    logic [IDW-1:0]   out_id_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_d;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   winner;
    logic             any_valid;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] sel_bin;
    logic             sel_dir;
    logic [WIDTH-1:0] conv;

    gray_rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .winner    (winner),
        .any_valid (any_valid)
    );

    always_comb begin
        can_accept = (state_q == ST_EMPTY) || out_ready;
        // Gated by rst_n so no grant is ever shown while reset is asserted.
        accept     = rst_n && can_accept && any_valid;
        req_ready  = accept ? grant : '0;
        ptr_d      = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;

        sel_bin = req_bin[int'(winner)*WIDTH +: WIDTH];
`ifdef GRAY_CONV_DECODE_EN
        sel_dir = req_dir[winner];
`else
        sel_dir = DIR_B2G;
`endif
        if (sel_dir == DIR_G2B) begin
            conv = WIDTH'(gray2bin(MAX_W'(sel_bin), WIDTH));
        end else begin
            conv = WIDTH'(bin2gray(MAX_W'(sel_bin), WIDTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            out_gray_q  <= '0;
            out_id_q    <= '0;
            ptr_q       <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_q     <= ST_FULL;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (out_ready && !accept) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                end
            endcase

            if (accept) begin
                out_gray_q <= conv;
                out_id_q   <= winner;
                ptr_q      <= ptr_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_gray  = out_gray_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter (default build): directed literal checks plus
// randomized traffic compared every cycle against a behavioural model.
module tb_gray_conv_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_bin = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_gray;
    logic [IDW-1:0]        out_id;
    logic                  out_ready = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    gray_conv_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_bin   (req_bin),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_gray  (out_gray),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic            m_full = 1'b0;
    logic [3:0]      m_gray = '0;
    int              m_id = 0;
    int              m_ptr = 0;
    logic [NREQ-1:0] m_last_grant = '0;

    function automatic logic [3:0] model_gray(input logic [3:0] b);
        logic [3:0] g;
        for (int i = 0; i < WIDTH; i++) begin
            g[i] = (i == WIDTH - 1) ? b[i] : (b[i] != b[i+1]);
        end
        return g;
    endfunction

    function automatic int model_winner();
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_ready();
        int w;
        logic [NREQ-1:0] r;
        r = '0;
        w = model_winner();
        if (rst_n && (!m_full || out_ready) && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_full       <= 1'b0;
            m_ptr        <= 0;
            m_last_grant <= '0;
        end else begin
            w = model_winner();
            if ((!m_full || out_ready) && w >= 0) begin
                m_full       <= 1'b1;
                m_gray       <= model_gray(req_bin[w*WIDTH +: WIDTH]);
                m_id         <= w;
                m_ptr        <= (w + 1) % NREQ;
                m_last_grant <= NREQ'(1 << w);
            end else begin
                m_last_grant <= '0;
                if (out_ready) m_full <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("cmp_req_ready", 32'(req_ready), 32'(model_ready()));
        check("cmp_out_valid", 32'(out_valid), 32'(m_full));
        if (m_full) begin
            check("cmp_out_gray", 32'(out_gray), 32'(m_gray));
            check("cmp_out_id", 32'(out_id), 32'(m_id));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_g [4];

    initial begin
        exp_g = '{4'b0010, 4'b0100, 4'b1110, 4'b0010};

        // Reset with every requester asking: no grant, outputs cleared.
        req_valid = '1;
        req_bin   = {4'b0011, 4'b1011, 4'b0111, 4'b0011};
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_gray", 32'(out_gray), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;

        // Round-robin through all four, first grant to 0.
        for (int i = 0; i < 4; i++) begin
            #2;
            check("rr_grant", 32'(req_ready), 32'(1 << i));
            tick();
            check("rr_valid", 32'(out_valid), 32'd1);
            check("rr_gray", 32'(out_gray), 32'(exp_g[i]));
            check("rr_id", 32'(out_id), 32'(i));
        end

        // Back-pressure: three stalled cycles, then no-bubble accept.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("bp_ready", 32'(req_ready), 32'd0);
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_gray", 32'(out_gray), 32'b0010);
            check("bp_id", 32'(out_id), 32'd3);
        end
        out_ready = 1'b1;
        #2;
        check("bp_release_grant", 32'(req_ready), 32'b0001);
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd1);
        check("bp_release_id", 32'(out_id), 32'd0);

        // Skip/wrap: steer ptr to 3, then 0101 grants 0 then 2.
        req_valid = 4'b0100;
        #2;
        check("skip_grant2", 32'(req_ready), 32'b0100);
        tick();
        check("skip_gray2", 32'(out_gray), 32'b1110);
        req_valid = 4'b0101;
        #2;
        check("wrap_grant0", 32'(req_ready), 32'b0001);
        tick();
        check("wrap_id0", 32'(out_id), 32'd0);
        #2;
        check("wrap_grant2", 32'(req_ready), 32'b0100);
        tick();
        check("wrap_id2", 32'(out_id), 32'd2);

        // No valid requests: no grant, output drains.
        req_valid = '0;
        #2;
        check("idle_ready", 32'(req_ready), 32'd0);
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);

        // Single request from requester 1.
        req_valid       = 4'b0010;
        req_bin[7:4]    = 4'b1011;
        #2;
        check("single_grant", 32'(req_ready), 32'b0010);
        tick();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_gray", 32'(out_gray), 32'b1110);
        check("single_id", 32'(out_id), 32'd1);

        // Reset mid-operation with a pending result.
        req_valid = '1;
        out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_gray", 32'(out_gray), 32'd0);
        check("midrst_id", 32'(out_id), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #2;
        check("postrst_grant", 32'(req_ready), 32'b0001);
        tick();

        // Randomized traffic honouring the hold-while-pending rule.
        repeat (3000) begin
            out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && !m_last_grant[i]) begin
                    if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i]              = 1'($urandom_range(0, 1));
                    req_bin[i*WIDTH +: WIDTH] = 4'($urandom);
                end
            end
            tick();
        end

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
